// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - borrow_in, LSB first, one full-subtractor cell reused WIDTH times
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             ovf_out
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, am_q, am_d, bm_q, bm_d, bo_q, bo_d, ov_q, ov_d;
  logic             cell_d, cell_b, last, accept;
  assign cell_d = a_q[0] ^ b_q[0] ^ br_q;
  assign cell_b = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign last   = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign accept = start && (state_q != SHIFT);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // next state: start is only honoured outside SHIFT
  always_comb begin
    state_d = (state_q == SHIFT) ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
  end
  // state-decoded outputs
  always_comb begin
    busy = state_q == SHIFT;
    done = state_q == DONE;
  end
  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sh_q   <= '0;
      diff_q <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      am_q   <= 1'b0;
      bm_q   <= 1'b0;
      bo_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sh_q   <= sh_d;
      diff_q <= diff_d;
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      am_q   <= am_d;
      bm_q   <= bm_d;
      bo_q   <= bo_d;
      ov_q   <= ov_d;
    end
  end
  // capture operands on accept, then one cell step per cycle; results land only on the last step
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sh_d   = sh_q;
    diff_d = diff_q;
    cnt_d  = cnt_q;
    br_d   = br_q;
    am_d   = am_q;
    bm_d   = bm_q;
    bo_d   = bo_q;
    ov_d   = ov_q;
    if (accept) begin
      a_d   = a_in;
      b_d   = b_in;
      br_d  = borrow_in;
      cnt_d = '0;
      am_d  = a_in[WIDTH-1];
      bm_d  = b_in[WIDTH-1];
    end else if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = cell_b;
      sh_d  = {cell_d, sh_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        diff_d = {cell_d, sh_q[WIDTH-1:1]};
        bo_d   = cell_b;
        ov_d   = (am_q != bm_q) && (cell_d != am_q);
      end
    end
  end
  assign diff_out   = diff_q;
  assign borrow_out = bo_q;
  assign ovf_out    = ov_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, corner sequences, random and exhaustive WIDTH=4 checks
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, bin8 = 1'b0, start4 = 1'b0, bin4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic       busy8, done8, bo8, ov8, busy4, done4, bo4, ov4;
  int         tests = 0, fails = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff_out(diff8), .borrow_out(bo8), .ovf_out(ov8));
  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .borrow_in(bin4),
    .busy(busy4), .done(done4), .diff_out(diff4), .borrow_out(bo4), .ovf_out(ov4));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] d;
    logic       bo, ov;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // plain integer arithmetic: {ovf, borrow, diff}
  function automatic int model(input int w, input int a, input int b, input int bin);
    int r, sa, sb, sr, d, bo, ov;
    r  = a - b - bin;
    d  = r & ((1 << w) - 1);
    bo = (r < 0) ? 1 : 0;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sr = sa - sb - bin;
    ov = (sr > (1 << (w - 1)) - 1 || sr < -(1 << (w - 1))) ? 1 : 0;
    return (ov << 9) | (bo << 8) | d;
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin, output int res, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    lat = 1;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = (int'(ov8) << 9) | (int'(bo8) << 8) | int'(diff8);
  endtask

  task automatic run4(input int a, input int b, input int bin, output int res, output int lat);
    @(negedge clk);
    a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bin); start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 1;
    while (!done4 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    res = (int'(ov4) << 9) | (int'(bo4) << 8) | int'(diff4);
  endtask

  initial begin
    int res, lat, first, second, ndone;
    logic [7:0] ra, rb;
    logic       rbin;
    tbl[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    tbl[1] = '{8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[7] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_diff", int'(diff8), 0);
    chk("rst_borrow", int'(bo8), 0);
    chk("rst_ovf", int'(ov8), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].bin, res, lat);
      chk($sformatf("tbl%0d_latency", i), lat, 9);
      chk($sformatf("tbl%0d_diff", i), res & 8'hFF, int'(tbl[i].d));
      chk($sformatf("tbl%0d_borrow", i), (res >> 8) & 1, int'(tbl[i].bo));
      chk($sformatf("tbl%0d_ovf", i), (res >> 9) & 1, int'(tbl[i].ov));
      @(negedge clk);
      chk($sformatf("tbl%0d_done_pulse", i), int'(done8), 0);
    end

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      run8(ra, rb, rbin, res, lat);
      chk($sformatf("rnd%0d_latency", i), lat, 9);
      chk($sformatf("rnd%0d_result", i), res, model(8, int'(ra), int'(rb), int'(rbin)));
    end

    // start during SHIFT must be ignored
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
    first = -1; ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start8 = (k == 3);
      if (k == 3) begin a8 = 8'hFF; b8 = 8'hFF; end
      if (done8) begin
        ndone++;
        if (first < 0) first = k;
      end
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_latency", first, 9);
    chk("ign_diff", int'(diff8), 8'h23);

    // start held high: back-to-back results, outputs held during the second run
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
    first = -1; second = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done8) begin
        if (first < 0) begin
          first = k;
          chk("b2b_diff1", int'(diff8), 8'h23);
          a8 = 8'h80; b8 = 8'h01;
        end else if (second < 0) begin
          second = k;
          chk("b2b_diff2", int'(diff8), 8'h7F);
          chk("b2b_ovf2", int'(ov8), 1);
          start8 = 1'b0;
        end
      end
      if (first > 0 && k == first + 4) begin
        chk("b2b_hold_diff", int'(diff8), 8'h23);
        chk("b2b_hold_busy", int'(busy8), 1);
      end
    end
    chk("b2b_gap", second - first, 9);

    // reset part way through a run
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy8), 0);
    chk("mid_rst_done", int'(done8), 0);
    chk("mid_rst_diff", int'(diff8), 0);
    chk("mid_rst_borrow", int'(bo8), 0);
    chk("mid_rst_ovf", int'(ov8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("mid_rst_idle", ndone, 0);
    run8(8'h35, 8'h12, 1'b0, res, lat);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_result", res, 8'h23);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          run4(a, b, c, res, lat);
          chk($sformatf("w4_%0d_%0d_%0d_latency", a, b, c), lat, 5);
          chk($sformatf("w4_%0d_%0d_%0d_result", a, b, c), res, model(4, a, b, c));
        end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
